// File: rtl/sram_port_arbiter_if.sv
// One 32-bit word requester port into the SRAM arbiter: request fields in,
// single-cycle grant/done pulses and held read data out.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      we;
  logic [ADDR_WIDTH-2:0]     addr;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      gnt;
  logic                      done;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (output req, we, addr, be, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, done, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing a 16-bit SRAM between boot and cpu 32-bit ports; grant->done 3 cycles (write) / 4 (read).
// No backpressure beyond req-held-until-done: one access in flight, the losing requester waits with req high.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sram_port_arbiter_if.slave      boot,
  sram_port_arbiter_if.slave      cpu,
  output logic                    sram_ce_n,
  output logic                    sram_we_n,
  output logic                    sram_oe_n,
  output logic                    sram_ub_n,
  output logic                    sram_lb_n,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH/2-1:0] sram_wr_data,
  input  logic [DATA_WIDTH/2-1:0] sram_rd_data
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, LO, HI, CAP, DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-2:0] addr;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } txn_t;

  state_t              state, state_nxt;
  txn_t                txn, boot_txn, cpu_txn;
  logic                owner_boot;
  logic                last_cpu;
  logic                granted;
  logic                grant_window;
  logic                boot_cand, cpu_cand, pick_boot, grant_now;
  logic [HW-1:0]       lo_buf;
  logic                half_hi;
  logic [BW/2-1:0]     be_half;
  logic                ce_nxt, we_nxt, oe_nxt, ub_nxt, lb_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [HW-1:0]       wd_nxt;

  assign boot_txn = {boot.we, boot.addr, boot.be, boot.wdata};
  assign cpu_txn  = {cpu.we,  cpu.addr,  cpu.be,  cpu.wdata};
  assign granted  = boot.gnt | cpu.gnt;

  // The gnt pulse marks the IDLE cycle of an accepted request, so the decision
  // is taken on the edge entering that cycle. On leaving DONE the finishing
  // owner's req is still high from the old access and must not count.
  always_comb begin
    grant_window = ((state == IDLE) && !granted) || (state == DONE);
    boot_cand    = boot.req && grant_window && !((state == DONE) && owner_boot);
    cpu_cand     = cpu.req  && grant_window && !((state == DONE) && !owner_boot);
    pick_boot    = boot_cand && (!cpu_cand || last_cpu);
    grant_now    = boot_cand || cpu_cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (granted) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = txn.we ? DONE : CAP;
      CAP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values are precomputed from the upcoming state so every output is a flop.
  always_comb begin
    ce_nxt   = 1'b1;
    we_nxt   = 1'b1;
    oe_nxt   = 1'b1;
    ub_nxt   = 1'b1;
    lb_nxt   = 1'b1;
    addr_nxt = sram_addr;
    wd_nxt   = sram_wr_data;
    half_hi  = (state_nxt == HI);
    be_half  = half_hi ? txn.be[BW-1:BW/2] : txn.be[BW/2-1:0];
    if ((state_nxt == LO) || (state_nxt == HI)) begin
      addr_nxt = {txn.addr, half_hi};
      wd_nxt   = half_hi ? txn.wdata[DATA_WIDTH-1:HW] : txn.wdata[HW-1:0];
      if (txn.we) begin
        ce_nxt = ~|be_half;
        we_nxt = ~|be_half;
        ub_nxt = ~be_half[1];
        lb_nxt = ~be_half[0];
      end else begin
        ce_nxt = 1'b0;
        oe_nxt = 1'b0;
        ub_nxt = 1'b0;
        lb_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn          <= '0;
      owner_boot   <= 1'b0;
      last_cpu     <= 1'b1;
      lo_buf       <= '0;
      boot.gnt     <= 1'b0;
      cpu.gnt      <= 1'b0;
      boot.done    <= 1'b0;
      cpu.done     <= 1'b0;
      boot.rdata   <= '0;
      cpu.rdata    <= '0;
      sram_ce_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      sram_addr    <= '0;
      sram_wr_data <= '0;
    end else begin
      boot.gnt <= grant_now && pick_boot;
      cpu.gnt  <= grant_now && !pick_boot;
      if (grant_now) begin
        txn        <= pick_boot ? boot_txn : cpu_txn;
        owner_boot <= pick_boot;
        last_cpu   <= !pick_boot;
      end
      boot.done <= (state_nxt == DONE) && owner_boot;
      cpu.done  <= (state_nxt == DONE) && !owner_boot;
      // Read data lags the enabled cycle by one: LO data arrives in HI, HI data in CAP.
      if ((state == HI) && !txn.we) lo_buf <= sram_rd_data;
      if (state == CAP) begin
        if (owner_boot) boot.rdata <= {sram_rd_data, lo_buf};
        else            cpu.rdata  <= {sram_rd_data, lo_buf};
      end
      sram_ce_n    <= ce_nxt;
      sram_we_n    <= we_nxt;
      sram_oe_n    <= oe_nxt;
      sram_ub_n    <= ub_nxt;
      sram_lb_n    <= lb_nxt;
      sram_addr    <= addr_nxt;
      sram_wr_data <= wd_nxt;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the external 16-bit asynchronous-style SRAM port between two 32-bit word requesters: the bootloader (program/data load during boot) and the processor data port. Each granted 32-bit access is sequenced as two 16-bit SRAM half-word cycles, low half first, with per-byte masking via ub_n/lb_n. It sits in top between bootloader/processor and the sram_* pins that drive the board SRAM (sp_ram in simulation).

## Interface
- DATA_WIDTH, 32, requester word width (fixed 32; SRAM side is DATA_WIDTH/2)
- ADDR_WIDTH, 10, SRAM half-word address width; requester word address is ADDR_WIDTH-1 bits
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- boot_req / cpu_req  in  1  request; held high until matching *_done
- boot_we / cpu_we  in  1  1 = write, 0 = read
- boot_addr / cpu_addr  in  ADDR_WIDTH-1  word address
- boot_be / cpu_be  in  4  byte enables (bit0 = bits 7:0); ignored for reads
- boot_wdata / cpu_wdata  in  32  write data
- boot_gnt / cpu_gnt  out  1  one-cycle pulse: request accepted, fields sampled
- boot_done / cpu_done  out  1  one-cycle pulse: access complete
- boot_rdata / cpu_rdata  out  32  read data, valid with *_done, held until that requester's next read completes
- sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low
- sram_addr  out  ADDR_WIDTH  half-word address
- sram_wr_data  out  16  SRAM write data
- sram_rd_data  in  16  SRAM read data, valid the cycle after a read-enabled cycle

## Operation
- FSM states: IDLE, LO, HI, CAP, DONE.
- IDLE: if any req, pick winner, pulse its gnt, latch we/addr/be/wdata and owner, go LO. No req: stay.
- Arbitration round-robin: on simultaneous requests, winner is requester not granted last; last-grant pointer resets to cpu so boot wins the first tie. Single request always wins.
- LO: sram_addr = {addr,1'b0}, sram_wr_data = wdata[15:0]; lb_n = ~be[0], ub_n = ~be[1] (reads: both 0). Go HI.
- HI: sram_addr = {addr,1'b1}, wr_data = wdata[31:16], lb_n = ~be[2], ub_n = ~be[3]. Read: capture sram_rd_data into rdata[15:0] at end of cycle. Write: go DONE; read: go CAP.
- CAP (reads only): strobes idle; capture sram_rd_data into rdata[31:16]. Go DONE.
- DONE: pulse owner's done; owner's rdata updated (reads). Go IDLE.
- Strobes per access state: write: ce_n=0, we_n=0, oe_n=1; read: ce_n=0, we_n=1, oe_n=0. Write half with both its be bits 0: ce_n=1, we_n=1 (no cycle issued, state still spent).
- Outside LO/HI: ce_n=we_n=oe_n=ub_n=lb_n=1; sram_addr, sram_wr_data hold last value.
- req dropped before done: protocol violation; transaction still completes, done still pulsed.
- Other requester's rdata never modified.

## Timing
- All outputs registered; per-state values above are the pin values during that state's cycle.
- Grant cycle = T (IDLE). Write: LO T+1, HI T+2, done T+3. Read: LO T+1, HI T+2, CAP T+3, done T+4.
- Next grant earliest at T+4 (write) / T+5 (read); back-to-back requests from both sides alternate.
- Reset (async assert, any state): state IDLE, all sram strobes 1, sram_addr 0, sram_wr_data 0, gnt/done 0, both rdata 0, pointer = cpu. In-flight access aborted, no done issued. Deassertion takes effect at next clk edge; first grant earliest on the first edge after release.

## Test plan
- Boot write addr 0x005, be 0xF, wdata 0xDEADBEEF -> boot_gnt at T, sram_addr 0x00A/0x00B with wr_data 0xBEEF/0xDEAD and we_n=0 at T+1/T+2, boot_done at T+3.
- Cpu read addr 0x005 after above -> cpu_done at T+4, cpu_rdata = 0xDEADBEEF; oe_n=0 only in LO/HI; boot_rdata unchanged.
- Cpu write be 0x4, wdata 0x00AA0000 at addr 0x005 -> LO cycle ce_n=1; HI cycle lb_n=0, ub_n=1; subsequent read returns 0xDEAABEEF.
- boot_req and cpu_req asserted same cycle, held for 4 transactions each -> grants alternate boot, cpu, boot, cpu; every gnt paired with one done to same requester.
- rst_n low during HI of a write -> strobes 1 immediately (no clk needed), no done; after release, pending req granted and completes normally.
- Read with be = 0x0 -> be ignored, both halves read, ub_n=lb_n=0.
